revaluate_arbiter: RTL

//  Shares one revaluate engine (RevaluateController plus its row/col datapath) among NREQ requesters.
//  - Picks one pending requester round-robin and launches the engine with a one-cycle start pulse.
//  - Tracks the job until the engine's outReady, then returns a done pulse to the owner.
//  - Guards each job with a watchdog that aborts hung jobs.
//  - Sits between client layers and the engine; drives the engine's operand/result mux select.

---
 rtl/revaluate_pkg.sv | 37 +++
 rtl/revaluate_rr_pick.sv | 48 ++++
 rtl/revaluate_arbiter.sv | 161 ++++++++++++++++
 3 files changed

// File: rtl/revaluate_pkg.sv
// Shared definitions for the revaluate engine arbiter and the engine top.
//  - FSM state encodings of the arbiter (plain localparams so older code
//    that compares against raw codes keeps working).
//  - Default requester count and watchdog limit.
//  - Job status codes reported alongside a finished job.
//  - clog2 helper used to size select and watchdog counter widths.
package revaluate_pkg;

  localparam int NREQ_DEF    = 4;
  localparam int TIMEOUT_DEF = 1023;

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_ARB    = 3'd1;
  localparam logic [2:0] ST_LAUNCH = 3'd2;
  localparam logic [2:0] ST_WAIT   = 3'd3;
  localparam logic [2:0] ST_DONE   = 3'd4;
  localparam logic [2:0] ST_ABORT  = 3'd5;

  typedef enum logic [0:0] {
    JOB_OK      = 1'b0,
    JOB_TIMEOUT = 1'b1
  } job_status_e;

  // Number of bits needed to encode 'value' distinct codes (0..value-1).
  function automatic int clog2(input int value);
    int res;
    int v;
    res = 0;
    v   = value - 1;
    while (v > 0) begin
      res = res + 1;
      v   = v >>> 1;
    end
    return res;
  endfunction

endpackage

// File: rtl/revaluate_rr_pick.sv
// Rotating-priority requester pick (purely combinational).
// The search starts at ptr_i and wraps, so the requester just after the last
// owner has the highest priority.
// Ports:
//  req_i  in  NREQ  pending request levels
//  ptr_i  in  SELW  index with highest priority
//  gnt_o  out NREQ  one-hot winner (0 if nothing pending)
//  idx_o  out SELW  binary index of the winner (0 if nothing pending)
//  any_o  out 1     at least one request pending
module revaluate_rr_pick
  import revaluate_pkg::*;
#(
  parameter int NREQ = NREQ_DEF,
  parameter int SELW = clog2(NREQ)
) (
  input  logic [NREQ-1:0] req_i,
  input  logic [SELW-1:0] ptr_i,
  output logic [NREQ-1:0] gnt_o,
  output logic [SELW-1:0] idx_o,
  output logic            any_o
);

  function automatic logic [SELW-1:0] wrap_idx(input int base, input int off);
    int sum;
    sum = (base + off) % NREQ;
    return sum[SELW-1:0];
  endfunction

  logic [SELW-1:0] cand;
  logic            hit;

  // Walk the requesters from ptr_i upward with wrap; the first pending one wins.
  always_comb begin
    gnt_o = '0;
    idx_o = '0;
    any_o = 1'b0;
    cand  = '0;
    hit   = 1'b0;
    for (int i = 0; i < NREQ; i++) begin
      cand        = wrap_idx(int'(ptr_i), i);
      hit         = req_i[cand] & ~any_o;
      gnt_o[cand] = gnt_o[cand] | hit;
      idx_o       = hit ? cand : idx_o;
      any_o       = any_o | hit;
    end
  end

endmodule

// File: rtl/revaluate_arbiter.sv
// Shares one revaluate engine among NREQ requesters.
// A pending requester is picked round-robin, the engine is launched with a
// single start pulse, and the owner gets a done pulse when the engine's
// result is valid, or an err pulse if the watchdog expires first.
// Ports:
//  clk          in   1     clock, rising edge
//  rst          in   1     asynchronous active-low reset
//  req          in   NREQ  request levels, held until done/err
//  gnt          out  NREQ  one-hot owner, 0 when no job is in flight
//  engSel       out  SELW  binary owner index for engine operand/result muxes
//  engStart     out  1     start pulse to the engine controller
//  engReady     in   1     engine controller idle
//  engOutReady  in   1     engine result-valid pulse
//  done         out  NREQ  one-cycle completion pulse to the owner
//  err          out  NREQ  one-cycle watchdog-abort pulse to the owner
//  busy         out  1     arbiter not idle
module revaluate_arbiter
  import revaluate_pkg::*;
#(
  parameter int NREQ    = NREQ_DEF,
  parameter int TIMEOUT = TIMEOUT_DEF,
  parameter int SELW    = clog2(NREQ),
  parameter int CNTW    = clog2(TIMEOUT + 1)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [NREQ-1:0] req,
  output logic [NREQ-1:0] gnt,
  output logic [SELW-1:0] engSel,
  output logic            engStart,
  input  logic            engReady,
  input  logic            engOutReady,
  output logic [NREQ-1:0] done,
  output logic [NREQ-1:0] err,
  output logic            busy
);

  logic [2:0]      state_q, state_d;
  logic [SELW-1:0] ptr_q, ptr_d;
  logic [CNTW-1:0] cnt_q, cnt_d;
  logic [NREQ-1:0] gnt_q, gnt_d;
  logic [SELW-1:0] sel_q, sel_d;
  // High during the first cycle after any state change; marks ABORT entry.
  logic            entry_q;

  logic [NREQ-1:0] pick_gnt;
  logic [SELW-1:0] pick_idx;
  logic            pick_any;
  logic [SELW-1:0] owner_inc;

  revaluate_rr_pick #(
    .NREQ (NREQ),
    .SELW (SELW)
  ) u_pick (
    .req_i (req),
    .ptr_i (ptr_q),
    .gnt_o (pick_gnt),
    .idx_o (pick_idx),
    .any_o (pick_any)
  );

  // Requester after the current owner, wrapping at NREQ.
  assign owner_inc = (sel_q == SELW'(NREQ - 1)) ? '0 : sel_q + SELW'(1);

  // Next-state logic for the job FSM and its side registers.
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    cnt_d   = cnt_q;
    gnt_d   = gnt_q;
    sel_d   = sel_q;
    case (state_q)
      ST_IDLE: begin
        if (|req) begin
          state_d = ST_ARB;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_ARB: begin
        // A requester that withdrew before arbitration gets nothing.
        if (pick_any) begin
          state_d = ST_LAUNCH;
          gnt_d   = pick_gnt;
          sel_d   = pick_idx;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_LAUNCH: begin
        if (engReady) begin
          state_d = ST_WAIT;
          cnt_d   = '0;
        end else begin
          state_d = ST_LAUNCH;
        end
      end
      ST_WAIT: begin
        // Saturating watchdog; a result in the last allowed cycle still wins.
        cnt_d = (cnt_q == CNTW'(TIMEOUT)) ? cnt_q : cnt_q + CNTW'(1);
        if (engOutReady) begin
          state_d = ST_DONE;
        end else if (cnt_q == CNTW'(TIMEOUT)) begin
          state_d = ST_ABORT;
        end else begin
          state_d = ST_WAIT;
        end
      end
      ST_DONE: begin
        ptr_d   = owner_inc;
        state_d = ST_IDLE;
        gnt_d   = '0;
        sel_d   = '0;
      end
      ST_ABORT: begin
        ptr_d = owner_inc;
        // Hold the grant until the engine has drained the aborted job.
        if (engReady) begin
          state_d = ST_IDLE;
          gnt_d   = '0;
          sel_d   = '0;
        end else begin
          state_d = ST_ABORT;
        end
      end
      default: begin
        state_d = ST_IDLE;
        gnt_d   = '0;
        sel_d   = '0;
      end
    endcase
  end

  // State and job-tracking registers; reset drops any job in flight.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_IDLE;
      ptr_q   <= '0;
      cnt_q   <= '0;
      gnt_q   <= '0;
      sel_q   <= '0;
      entry_q <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      cnt_q   <= cnt_d;
      gnt_q   <= gnt_d;
      sel_q   <= sel_d;
      entry_q <= (state_d != state_q);
    end
  end

  assign gnt      = gnt_q;
  assign engSel   = sel_q;
  // Start is only issued when the controller can sample it, so one pulse per job.
  assign engStart = (state_q == ST_LAUNCH) & engReady;
  assign done     = (state_q == ST_DONE) ? gnt_q : '0;
  assign err      = ((state_q == ST_ABORT) && entry_q) ? gnt_q : '0;
  assign busy     = (state_q != ST_IDLE);

endmodule
